player_cmd_scheduler: RTL and testbench
=======================================

Name: player_cmd_scheduler

Overview:
- Central command scheduler for the music player. It sits between the user buttons plus the end-of-song condition and the address, song-select and timer datapaths.
- Captures each request as a pending bit and arbitrates by fixed priority.
- Issues exactly one command per slot, with a hold-off gap between commands, so seek, song-change and play/pause never reach the datapath in the same cycle.
- Owns the song select, start pulse, play flag and time_adder value.

Parameters:
- NUM_SONGS, 4: number of songs; song_select wraps modulo this value; must be 2..4.
- SEEK_SHORT, 10: seconds for short seek, emitted as +/- on time_adder.
- SEEK_LONG, 30: seconds for long seek.
- HOLDOFF, 3: idle cycles after each issued command before the next arbitration; 0 is legal.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pass_30s, back_30s, pass_10s, back_10s  in  1 each  seek buttons, level, synchronous to clk
- next_song, prev_song, play_pause  in  1 each  buttons, level
- end_of_song  in  1  level; high when the current song is exhausted
- busy  in  1  downstream busy; blocks arbitration while high
- cmd_valid  out  1  one-cycle pulse marking an issued command
- cmd_code  out  3  issued command, valid only while cmd_valid=1
- time_adder  out  9 signed  seconds added to the timer each tick
- song_select  out  2  current song index
- start  out  1  one-cycle pulse on any song change
- play  out  1  1 = playing, 0 = paused
- pending  out  8  pending request bits, for debug and display

Behaviour:
- Reset (async, immediate):
  - state=IDLE; pending=0; song_select=0; play=0; start=0; cmd_valid=0; cmd_code=0; time_adder=+1; hold counter=0.
  - All edge-detect history registers reset to 1, so inputs already high at reset release produce no event.
- Edge detection: an event is input=1 with last-cycle input=0. One register per input; end_of_song is edge-detected the same way.
- Pending bits and priority, bit 7 highest:
  - 7 end_of_song (code 0), 6 next (1), 5 prev (2), 4 play_pause (3), 3 +long (4), 2 -long (5), 1 +short (6), 0 -short (7).
  - An event sets its bit.
  - A repeat event on an already-set bit coalesces into one command.
  - An event arriving in the same cycle its bit is being served leaves the bit set.
- FSM states and transitions:
  - IDLE: if pending!=0 and busy==0, latch the highest-priority bit, clear it, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): cmd_valid=1 and cmd_code=latched code. Side effects are registered at the end of this cycle. Next state is HOLD if HOLDOFF>0, else IDLE.
  - HOLD: count HOLDOFF cycles, then go to IDLE. Events keep accumulating in pending during HOLD.
- Side effects of ISSUE:
  - Codes 0 and 1: song_select=(song_select+1) mod NUM_SONGS.
  - Code 2: song_select=(song_select+NUM_SONGS-1) mod NUM_SONGS.
  - Codes 0-2: start=1 during ISSUE. Pending bits 3..0 are cleared, discarding stale seeks; no seek command is issued for a seek event in the same cycle as the served song change. The play flag is unchanged.
  - Code 3: play toggles.
  - Codes 4-7: time_adder=+SEEK_LONG, -SEEK_LONG, +SEEK_SHORT, -SEEK_SHORT respectively, during the ISSUE cycle only.
- time_adder outside ISSUE is +1. Seek values are sign-extended to 9 bits (range -256..255).
- busy:
  - Sampled only in IDLE.
  - busy rising during ISSUE or HOLD has no effect on the command already issued.
- Latency: an event at cycle N (busy=0, state IDLE) gives pending at N+1, ISSUE at N+2, and the effect visible at N+3.
- Reset asserted mid-ISSUE or mid-HOLD aborts immediately; nothing partial persists.

Test Plan:
- Reset with next_song held high, then release reset -> no command; song_select=0, play=0, time_adder=+1, pending=0.
- Pulse play_pause for 1 cycle -> exactly one cmd_valid with cmd_code=3, 2 cycles after the event; play=1 the next cycle; second pulse -> play=0.
- Pulse pass_10s and back_30s in the same cycle -> cmd_code=5 (time_adder=-30 for 1 cycle), then 4 HOLD/IDLE cycles later cmd_code=6 (time_adder=+10); no other cycle shows time_adder!=+1.
- song_select=3 with NUM_SONGS=4, pulse next_song -> song_select=0 and start=1 for 1 cycle; from 0, pulse prev_song -> song_select=3.
- Hold busy=1, then pulse pass_30s 3 times and prev_song once -> pending=8'b0010_1000 and no cmd_valid; drop busy -> only cmd_code=2 issued, pending=0 afterwards, and the seek is discarded.
- Assert reset during the HOLD cycle after a next_song command -> song_select=0, state IDLE, no further cmd_valid after reset release.

Source files
------------

// File: rtl/player_cmd_scheduler.sv
// player_cmd_scheduler: fixed-priority button/end-of-song scheduler issuing one command per slot with hold-off
module player_cmd_scheduler #(
  parameter int NUM_SONGS  = 4,
  parameter int SEEK_SHORT = 10,
  parameter int SEEK_LONG  = 30,
  parameter int HOLDOFF    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pass_30s,
  input  logic              back_30s,
  input  logic              pass_10s,
  input  logic              back_10s,
  input  logic              next_song,
  input  logic              prev_song,
  input  logic              play_pause,
  input  logic              end_of_song,
  input  logic              busy,
  output logic              cmd_valid,
  output logic [2:0]        cmd_code,
  output logic signed [8:0] time_adder,
  output logic [1:0]        song_select,
  output logic              start,
  output logic              play,
  output logic [7:0]        pending
);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  localparam int CW = $clog2(HOLDOFF + 2);
  localparam logic signed [8:0] SL = 9'(SEEK_LONG);
  localparam logic signed [8:0] SS = 9'(SEEK_SHORT);
  localparam logic [1:0] LAST = 2'(NUM_SONGS - 1);
  state_t state, state_n;
  logic [7:0] btn, prev, ev, pending_n;
  logic [2:0] code_n, hi;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] sel_n;
  logic play_n;
  // bit index equals priority; command code is 7 - bit
  assign btn = {end_of_song, next_song, prev_song, play_pause, pass_30s, back_30s, pass_10s, back_10s};
  assign ev = btn & ~prev;
  assign cmd_valid = state == ISSUE;
  assign start = cmd_valid && cmd_code <= 3'd2;
  assign time_adder = !cmd_valid || !cmd_code[2] ? 9'sd1 :
                      cmd_code[1:0] == 2'd0 ? SL :
                      cmd_code[1:0] == 2'd1 ? -SL :
                      cmd_code[1:0] == 2'd2 ? SS : -SS;
  always_comb begin
    hi = '0;
    for (int i = 0; i < 8; i++) if (pending[i]) hi = 3'(i);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      prev <= '1;
      pending <= '0;
      cmd_code <= '0;
      cnt <= '0;
      song_select <= '0;
      play <= 1'b0;
    end else begin
      state <= state_n;
      prev <= btn;
      pending <= pending_n;
      cmd_code <= code_n;
      cnt <= cnt_n;
      song_select <= sel_n;
      play <= play_n;
    end
  end
  always_comb begin
    state_n = state;
    pending_n = pending | ev;
    code_n = cmd_code;
    cnt_n = cnt;
    sel_n = song_select;
    play_n = play;
    case (state)
      IDLE: if (|pending && !busy) begin
        state_n = ISSUE;
        code_n = 3'd7 - hi;
        pending_n = (pending & ~(8'b1 << hi)) | ev;
      end
      ISSUE: begin
        state_n = HOLDOFF > 0 ? HOLD : IDLE;
        cnt_n = '0;
        // a song change makes any queued or simultaneous seek meaningless
        if (cmd_code <= 3'd2) begin
          pending_n = (pending | ev) & 8'hF0;
          sel_n = cmd_code == 3'd2 ? (song_select == 2'd0 ? LAST : song_select - 2'd1)
                                   : (song_select == LAST ? 2'd0 : song_select + 2'd1);
        end
        if (cmd_code == 3'd3) play_n = !play;
      end
      HOLD: if (cnt == CW'(HOLDOFF - 1)) state_n = IDLE;
            else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_player_cmd_scheduler.sv
// tb_player_cmd_scheduler: directed and randomized checks against a slot-based behavioural model
module tb_player_cmd_scheduler;
  localparam int NS = 4;
  localparam int HO = 3;
  logic clk = 0, reset = 1, busy = 0;
  logic [7:0] btn = '0;
  logic cmd_valid, start, play;
  logic [2:0] cmd_code;
  logic signed [8:0] time_adder;
  logic [1:0] song_select;
  logic [7:0] pending;
  logic [24:0] obs;
  int checks = 0, errors = 0;
  logic [7:0] m_pend, m_prev;
  int m_sel, m_code, m_cyc, m_ready;
  bit m_play, m_issue;

  player_cmd_scheduler #(.NUM_SONGS(NS), .SEEK_SHORT(10), .SEEK_LONG(30), .HOLDOFF(HO)) dut (
    .clk(clk), .reset(reset),
    .pass_30s(btn[3]), .back_30s(btn[2]), .pass_10s(btn[1]), .back_10s(btn[0]),
    .next_song(btn[6]), .prev_song(btn[5]), .play_pause(btn[4]), .end_of_song(btn[7]),
    .busy(busy), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .time_adder(time_adder),
    .song_select(song_select), .start(start), .play(play), .pending(pending)
  );

  always #5 clk = ~clk;
  assign obs = {cmd_valid, cmd_valid ? cmd_code : 3'd0, start, time_adder, song_select, play, pending};

  function automatic logic [24:0] expv();
    int ta;
    ta = !m_issue ? 1 : m_code == 4 ? 30 : m_code == 5 ? -30 : m_code == 6 ? 10 : m_code == 7 ? -10 : 1;
    return {m_issue, m_issue ? 3'(m_code) : 3'd0, m_issue && m_code <= 2, 9'(ta), 2'(m_sel), m_play, m_pend};
  endfunction

  task automatic model_reset();
    m_pend = '0; m_prev = '1; m_sel = 0; m_play = 0; m_issue = 0; m_code = 0; m_cyc = 0; m_ready = 0;
  endtask

  // one command slot: issue cycle, then HO quiet cycles before the next grant
  task automatic model_step(input logic [7:0] in, input logic b);
    logic [7:0] ev;
    ev = in & ~m_prev;
    m_prev = in;
    if (m_issue) begin
      m_issue = 0;
      m_ready = m_cyc + 1 + HO;
      if (m_code <= 2) begin
        m_sel = m_code == 2 ? (m_sel + NS - 1) % NS : (m_sel + 1) % NS;
        m_pend = (m_pend | ev) & 8'hF0;
      end else begin
        if (m_code == 3) m_play = !m_play;
        m_pend = m_pend | ev;
      end
    end else if (m_cyc >= m_ready && m_pend != 0 && !b) begin
      for (int i = 7; i >= 0; i--) if (m_pend[i]) begin
        m_code = 7 - i;
        m_pend[i] = 1'b0;
        break;
      end
      m_pend = m_pend | ev;
      m_issue = 1;
    end else m_pend = m_pend | ev;
    m_cyc++;
  endtask

  task automatic tick(input logic [7:0] in, input logic b);
    btn = in;
    busy = b;
    model_step(in, b);
    @(negedge clk);
  endtask

  task automatic test_reset();
    btn = 8'h40;
    reset = 1;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_valid, start, time_adder, song_select, play, pending} !== {1'b0, 1'b0, 9'sd1, 2'd0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", {cmd_valid, start, time_adder, song_select, play, pending}, {1'b0, 1'b0, 9'sd1, 2'd0, 1'b0, 8'h00});
    end
    reset = 0;
    repeat (6) begin
      tick(8'h40, 0);
      checks++;
      if (cmd_valid !== 1'b0 || pending !== 8'h00 || song_select !== 2'd0 || time_adder !== 9'sd1) begin
        errors++;
        $display("FAIL held_at_reset: got valid=%b pend=%h sel=%0d ta=%0d expected 0 00 0 1", cmd_valid, pending, song_select, time_adder);
      end
    end
    tick(8'h00, 0);
  endtask

  task automatic test_play_pause();
    for (int p = 0; p < 2; p++) begin
      tick(8'h10, 0);
      checks++;
      if (pending !== 8'h10 || cmd_valid !== 1'b0) begin
        errors++;
        $display("FAIL pp_pending: got pend=%h valid=%b expected 10 0", pending, cmd_valid);
      end
      tick(8'h00, 0);
      checks++;
      if (cmd_valid !== 1'b1 || cmd_code !== 3'd3 || start !== 1'b0) begin
        errors++;
        $display("FAIL pp_issue: got valid=%b code=%0d start=%b expected 1 3 0", cmd_valid, cmd_code, start);
      end
      tick(8'h00, 0);
      checks++;
      if (play !== (p == 0) || cmd_valid !== 1'b0) begin
        errors++;
        $display("FAIL pp_toggle: got play=%b valid=%b expected %b 0", play, cmd_valid, p == 0);
      end
      repeat (4) tick(8'h00, 0);
    end
  endtask

  task automatic test_seek_pair();
    tick(8'h06, 0);
    for (int k = 1; k <= 11; k++) begin
      tick(8'h00, 0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL seek_model k=%0d: got %h expected %h", k, obs, expv());
      end
      checks++;
      if (k == 1 ? (cmd_valid !== 1'b1 || cmd_code !== 3'd5 || time_adder !== -9'sd30) :
          k == 6 ? (cmd_valid !== 1'b1 || cmd_code !== 3'd6 || time_adder !== 9'sd10) :
                   (cmd_valid !== 1'b0 || time_adder !== 9'sd1)) begin
        errors++;
        $display("FAIL seek_seq k=%0d: got valid=%b code=%0d ta=%0d", k, cmd_valid, cmd_code, time_adder);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] pulses [2] = '{8'h20, 8'h40};
    logic [1:0] sels [2] = '{2'd3, 2'd0};
    for (int j = 0; j < 2; j++) begin
      tick(pulses[j], 0);
      tick(8'h00, 0);
      checks++;
      if (start !== 1'b1 || cmd_code !== (j == 0 ? 3'd2 : 3'd1)) begin
        errors++;
        $display("FAIL wrap_issue%0d: got start=%b code=%0d", j, start, cmd_code);
      end
      tick(8'h00, 0);
      checks++;
      if (song_select !== sels[j] || start !== 1'b0) begin
        errors++;
        $display("FAIL wrap_sel%0d: got sel=%0d start=%b expected %0d 0", j, song_select, start, sels[j]);
      end
      repeat (4) tick(8'h00, 0);
    end
  endtask

  task automatic test_busy();
    logic [7:0] seq [9] = '{8'h08, 8'h00, 8'h08, 8'h00, 8'h08, 8'h00, 8'h20, 8'h00, 8'h00};
    for (int k = 0; k < 9; k++) begin
      tick(seq[k], 1);
      checks++;
      if (cmd_valid !== 1'b0) begin
        errors++;
        $display("FAIL busy_block: got valid=%b expected 0", cmd_valid);
      end
    end
    checks++;
    if (pending !== 8'h28) begin
      errors++;
      $display("FAIL busy_pending: got %h expected 28", pending);
    end
    tick(8'h00, 0);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_code !== 3'd2) begin
      errors++;
      $display("FAIL busy_issue: got valid=%b code=%0d expected 1 2", cmd_valid, cmd_code);
    end
    repeat (8) begin
      tick(8'h00, 0);
      checks++;
      if (cmd_valid !== 1'b0 || pending !== 8'h00 || song_select !== 2'd3) begin
        errors++;
        $display("FAIL busy_discard: got valid=%b pend=%h sel=%0d expected 0 00 3", cmd_valid, pending, song_select);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    tick(8'h40, 0);
    repeat (6) tick(8'h00, 0);
    tick(8'h40, 0);
    tick(8'h00, 0);
    tick(8'h00, 0);
    checks++;
    if (song_select !== 2'd1 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_pre: got sel=%0d valid=%b expected 1 0", song_select, cmd_valid);
    end
    reset = 1;
    model_reset();
    #1;
    checks++;
    if (song_select !== 2'd0 || pending !== 8'h00 || cmd_valid !== 1'b0 || play !== 1'b0) begin
      errors++;
      $display("FAIL hold_abort: got sel=%0d pend=%h valid=%b play=%b", song_select, pending, cmd_valid, play);
    end
    @(negedge clk);
    reset = 0;
    repeat (8) begin
      tick(8'h00, 0);
      checks++;
      if (cmd_valid !== 1'b0 || song_select !== 2'd0) begin
        errors++;
        $display("FAIL post_reset: got valid=%b sel=%0d expected 0 0", cmd_valid, song_select);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      tick(8'($urandom & $urandom & $urandom), $urandom_range(0, 3) == 0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL random k=%0d: got %h expected %h", k, obs, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_play_pause();
    test_seek_pair();
    test_wrap();
    test_busy();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
